// File: rtl/vlane_exec_if.sv
// Instruction, vrf read and vrf write signals of the vlane_exec lane.
// master = issuing side plus vrf model, slave = the lane.
interface vlane_exec_if #(
  parameter int unsigned els_p  = 32,
  parameter int unsigned vlen_p = 8,
  parameter int unsigned vdw_p  = 32
);
  localparam int unsigned addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int unsigned vec_width_lp  = vlen_p * vdw_p;

  logic                                v_i;
  logic                                ready_o;
  logic [2:0]                          op_i;
  logic [addr_width_lp-1:0]            vs1_i;
  logic [addr_width_lp-1:0]            vs2_i;
  logic [addr_width_lp-1:0]            vd_i;
  logic [1:0][addr_width_lp-1:0]       r_addr_o;
  logic [1:0][vec_width_lp-1:0]        r_data_i;
  logic [addr_width_lp-1:0]            w_addr_o;
  logic [vec_width_lp-1:0]             w_data_o;
  logic                                w_en_o;
  logic                                done_o;
  logic                                err_o;

  modport master (
    output v_i, op_i, vs1_i, vs2_i, vd_i, r_data_i,
    input  ready_o, r_addr_o, w_addr_o, w_data_o, w_en_o, done_o, err_o
  );

  modport slave (
    input  v_i, op_i, vs1_i, vs2_i, vd_i, r_data_i,
    output ready_o, r_addr_o, w_addr_o, w_data_o, w_en_o, done_o, err_o
  );
endinterface

// File: rtl/vlane_exec.sv
// Element-serial vector lane: vd = vs1 OP vs2, one element per cycle.
// Optional element multiply (op 7) enabled by defining VLANE_MUL_EN.
module vlane_exec #(
  parameter int unsigned els_p  = 32,
  parameter int unsigned vlen_p = 8,
  parameter int unsigned vdw_p  = 32
) (
  input  logic          clk_i,
  input  logic          reset_i,
  vlane_exec_if.slave   bus
);
  localparam int unsigned addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int unsigned cnt_width_lp  = (vlen_p > 1) ? $clog2(vlen_p) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_EXEC = 2'd2;
  localparam logic [1:0] ST_WB   = 2'd3;

  logic [1:0]                     r_state;
  logic [1:0]                     w_state_nxt;
  logic [2:0]                     r_op;
  logic [addr_width_lp-1:0]       r_vd;
  logic [1:0][addr_width_lp-1:0]  r_addr;
  logic [vlen_p-1:0][vdw_p-1:0]   r_a;
  logic [vlen_p-1:0][vdw_p-1:0]   r_b;
  logic [vlen_p-1:0][vdw_p-1:0]   r_res;
  logic [cnt_width_lp-1:0]        r_cnt;

  logic                           w_xfer;
  logic                           w_last;
  logic                           w_illegal;
  logic [vdw_p-1:0]               w_ea;
  logic [vdw_p-1:0]               w_eb;
  logic [vdw_p-1:0]               w_elem;

  assign w_xfer = bus.v_i && (r_state == ST_IDLE);
  assign w_last = (r_cnt == cnt_width_lp'(vlen_p - 1));
  assign w_ea   = r_a[r_cnt];
  assign w_eb   = r_b[r_cnt];

`ifdef VLANE_MUL_EN
  assign w_illegal = 1'b0;
`else
  assign w_illegal = (r_op == 3'd7);
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_xfer) w_state_nxt = ST_READ;
      ST_READ: w_state_nxt = ST_EXEC;
      ST_EXEC: if (w_last) w_state_nxt = ST_WB;
      ST_WB:   w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Element ALU; add/sub/mul wrap to vdw_p bits
  always_comb begin
    w_elem = '0;
    case (r_op)
      3'd0: w_elem = w_ea + w_eb;
      3'd1: w_elem = w_ea - w_eb;
      3'd2: w_elem = w_ea & w_eb;
      3'd3: w_elem = w_ea | w_eb;
      3'd4: w_elem = w_ea ^ w_eb;
      3'd5: w_elem = ($signed(w_ea) < $signed(w_eb)) ? w_ea : w_eb;
      3'd6: w_elem = ($signed(w_ea) > $signed(w_eb)) ? w_ea : w_eb;
`ifdef VLANE_MUL_EN
      3'd7: w_elem = w_ea * w_eb;
`endif
      default: w_elem = '0;
    endcase
  end

  // Instruction latch, operand buffers, element counter and result buffer
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_op   <= '0;
      r_vd   <= '0;
      r_addr <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_xfer) begin
        r_op      <= bus.op_i;
        r_vd      <= bus.vd_i;
        r_addr[0] <= bus.vs1_i;
        r_addr[1] <= bus.vs2_i;
      end
      if (r_state == ST_READ) begin
        r_a   <= bus.r_data_i[0];
        r_b   <= bus.r_data_i[1];
        r_cnt <= '0;
      end
      if (r_state == ST_EXEC) begin
        r_res[r_cnt] <= w_elem;
        r_cnt        <= w_last ? '0 : r_cnt + cnt_width_lp'(1);
      end
    end
  end

  assign bus.ready_o  = (r_state == ST_IDLE);
  assign bus.w_en_o   = (r_state == ST_WB) && !w_illegal;
  assign bus.done_o   = (r_state == ST_WB);
  assign bus.err_o    = (r_state == ST_WB) && w_illegal;
  assign bus.r_addr_o = r_addr;
  assign bus.w_addr_o = r_vd;
  assign bus.w_data_o = r_res;
endmodule
